bp_fe_gselect: RTL and testbench
================================

# bp_fe_gselect

Gselect conditional-branch direction predictor for the front end. It indexes a table of saturating counters with branch-address bits concatenated with a global history register (GHR). It returns a registered taken/not-taken prediction and trains counters and history from correct/incorrect feedback. It sits beside the BTB in the fetch stage; the back end supplies resolution feedback.

## Interface
- bht_idx_width_p, 9, total counter-table index width; table depth 2^bht_idx_width_p
- bp_cnt_sat_bits_p, 2, saturating counter width (≥2); MSB is the predicted direction
- bp_n_hist, 6, GHR length; legal range 1 ≤ bp_n_hist < bht_idx_width_p

Ports:
- clk_i  in  1  clock, all state on rising edge
- reset_n_i  in  1  asynchronous, active-low reset (one clock domain)
- w_v_i  in  1  update valid
- idx_w_i  in  bht_idx_width_p  branch index of resolved branch
- correct_i  in  1  1 = earlier prediction for this branch was correct
- r_v_i  in  1  prediction request valid
- idx_r_i  in  bht_idx_width_p  branch index to predict
- predict_o  out  1  registered prediction, 1 = taken

## Operation
- Table index: {idx[bht_idx_width_p-bp_n_hist-1:0], ghr[bp_n_hist-1:0]}, with GHR in the low bits. Upper idx bits are ignored.
- Read: when r_v_i=1, predict_o <= MSB of counter at index(idx_r_i, GHR). When r_v_i=0, predict_o holds.
- Update: when w_v_i=1, let c = counter at index(idx_w_i, GHR) and p = MSB(c).
  - correct_i=1: move c toward p. If p=1, c = min(c+1, 2^n-1); if p=0, c = max(c-1, 0).
  - correct_i=0: move c away from p. If p=0, c+1; if p=1, c-1. These never overflow.
- Resolved outcome t = p XOR ~correct_i.
- GHR <= {ghr[bp_n_hist-2:0], t} (shift left, newest bit at LSB) on the same edge as the counter write.
- GHR changes only on w_v_i.
- Reading and updating are independent. When both fire in one cycle:
  - both indices use the pre-edge GHR;
  - the read sees the pre-update counter value, even at the same entry.
- Counter arithmetic is unsigned, bp_cnt_sat_bits_p wide, with no wrap-around.

## Timing
- Reset (reset_n_i=0, asynchronous assert):
  - every counter = 2^(n-1)-1 (weakly not-taken; 2'b01 for n=2);
  - GHR = 0;
  - predict_o = 0.
- Reset release takes effect at the first rising edge with reset_n_i=1. Mid-operation reset discards all state immediately.
- Read latency: 1 cycle; predict_o is valid the cycle after r_v_i. No stall or backpressure; a request is accepted every cycle.
- Update latency: written at the edge where w_v_i=1. A read in the next cycle observes the new counter and the new GHR.
- No handshakes; every valid is single-cycle and always accepted.

## Structure
- Shared package bp_fe_gselect_pkg:
  - counter reset-value constant;
  - index-formation function (idx, ghr → table index).
- One sub-module, bp_fe_sat_cnt_update (combinational): inputs counter and correct; outputs next counter and outcome t. Parameterised by bp_cnt_sat_bits_p.
- Counter table: a flop array, needed for the asynchronous reset of all entries.
- GHR: a single shift register.

## Test plan
All cases use default parameters.
- Reset then read: reset_n_i=0→1, r_v_i=1 with idx_r_i=0x000 → predict_o=0 next cycle; any idx gives 0.
- Mispredict training: GHR=0, w_v_i=1, idx_w_i=0x005, correct_i=0 → counter[0x140]=2, GHR=0b000001.
  - Then w_v_i=1, idx_w_i=0x005, correct_i=1 (counter[0x141]=1, p=0) → counter[0x141]=0, t=0, GHR=0b000010.
- Saturation: drive one index repeatedly with GHR held constant (return to it by forcing a known outcome sequence); repeated correct on a counter at 3 keeps it at 3; repeated correct on a counter at 0 keeps it at 0.
- Same-cycle read/write on the same entry: r_v_i=1 and w_v_i=1 with an identical index, counter=1, correct_i=0 → predict_o=0 (old value); a read next cycle with the updated GHR reflects new history.
- History selection: same idx_r_i under GHR=0 and GHR=1 → distinct entries; training one does not change the other's prediction.
- Asynchronous reset mid-run: assert reset_n_i between edges after training → predict_o=0 immediately; all counters and GHR are restored.

Source files
------------

// File: rtl/bp_fe_gselect_pkg.sv
// Shared helpers for the gselect predictor: counter reset value and table index formation.
package bp_fe_gselect_pkg;

  localparam int unsigned IdxWidthDef = 9;
  localparam int unsigned CntBitsDef  = 2;
  localparam int unsigned NHistDef    = 6;

  // Weakly not-taken: MSB clear, all lower bits set.
  function automatic logic [31:0] cnt_reset_val(input int unsigned cnt_bits);
    return (32'd1 << (cnt_bits - 1)) - 32'd1;
  endfunction

  // {idx[idx_w-n_hist-1:0], ghr[n_hist-1:0]}; callers truncate to idx_w bits.
  function automatic logic [31:0] bht_index(input logic [31:0] idx,
                                            input logic [31:0] ghr,
                                            input int unsigned idx_w,
                                            input int unsigned n_hist);
    logic [31:0] hist_mask;
    logic [31:0] idx_mask;
    hist_mask = (32'd1 << n_hist) - 32'd1;
    idx_mask  = (32'd1 << idx_w) - 32'd1;
    return ((idx << n_hist) | (ghr & hist_mask)) & idx_mask;
  endfunction

endpackage

// File: rtl/bp_fe_sat_cnt_update.sv
// Saturating counter training step and resolved branch outcome.
module bp_fe_sat_cnt_update #(
  parameter int unsigned bp_cnt_sat_bits_p = 2
) (
  input  logic [bp_cnt_sat_bits_p-1:0] cnt_i,
  input  logic                         correct_i,
  output logic [bp_cnt_sat_bits_p-1:0] cnt_nxt_o,
  output logic                         taken_o
);

  localparam int unsigned CntW = bp_cnt_sat_bits_p;
  localparam logic [CntW-1:0] CntMax = '1;

  logic pred;
  assign pred = cnt_i[CntW-1];

  // Correct moves toward the predicted direction (saturating); wrong moves away.
  always_comb begin
    cnt_nxt_o = cnt_i;
    if (correct_i) begin
      if (pred) begin
        if (cnt_i != CntMax) cnt_nxt_o = cnt_i + CntW'(1);
      end else begin
        if (cnt_i != '0) cnt_nxt_o = cnt_i - CntW'(1);
      end
    end else if (pred) begin
      cnt_nxt_o = cnt_i - CntW'(1);
    end else begin
      cnt_nxt_o = cnt_i + CntW'(1);
    end
  end

  assign taken_o = pred ^ ~correct_i;

endmodule

// File: rtl/bp_fe_gselect.sv
// Gselect direction predictor: branch index bits concatenated with global history select a counter.
module bp_fe_gselect
  import bp_fe_gselect_pkg::*;
#(
  parameter int unsigned bht_idx_width_p   = IdxWidthDef,
  parameter int unsigned bp_cnt_sat_bits_p = CntBitsDef,
  parameter int unsigned bp_n_hist         = NHistDef
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       w_v_i,
  input  logic [bht_idx_width_p-1:0] idx_w_i,
  input  logic                       correct_i,
  input  logic                       r_v_i,
  input  logic [bht_idx_width_p-1:0] idx_r_i,
  output logic                       predict_o
);

  localparam int unsigned IdxW  = bht_idx_width_p;
  localparam int unsigned CntW  = bp_cnt_sat_bits_p;
  localparam int unsigned NHist = bp_n_hist;
  localparam int unsigned Depth = 1 << IdxW;
  localparam logic [CntW-1:0] CntRst = CntW'(cnt_reset_val(CntW));

  logic [CntW-1:0]  cnt_q [Depth];
  logic [NHist-1:0] ghr_q;
  logic [NHist-1:0] ghr_d;
  logic             predict_q;

  logic [IdxW-1:0]  r_idx;
  logic [IdxW-1:0]  w_idx;
  logic [CntW-1:0]  r_cnt;
  logic [CntW-1:0]  w_cnt;
  logic [CntW-1:0]  w_cnt_d;
  logic             w_taken;

  // Both ports index with the pre-edge history.
  assign r_idx = IdxW'(bht_index(32'(idx_r_i), 32'(ghr_q), IdxW, NHist));
  assign w_idx = IdxW'(bht_index(32'(idx_w_i), 32'(ghr_q), IdxW, NHist));
  assign r_cnt = cnt_q[r_idx];
  assign w_cnt = cnt_q[w_idx];

  bp_fe_sat_cnt_update #(
    .bp_cnt_sat_bits_p(CntW)
  ) u_cnt_update (
    .cnt_i    (w_cnt),
    .correct_i(correct_i),
    .cnt_nxt_o(w_cnt_d),
    .taken_o  (w_taken)
  );

  assign ghr_d = NHist'({ghr_q, w_taken});

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < Depth; i++) cnt_q[i] <= CntRst;
      ghr_q     <= '0;
      predict_q <= 1'b0;
    end else begin
      if (r_v_i) predict_q <= r_cnt[CntW-1];
      if (w_v_i) begin
        cnt_q[w_idx] <= w_cnt_d;
        ghr_q        <= ghr_d;
      end
    end
  end

  assign predict_o = predict_q;

endmodule

// File: tb/tb_bp_fe_gselect.sv
// Directed self-checking bench for bp_fe_gselect with default parameters.
module tb_bp_fe_gselect;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       w_v_i;
  logic [8:0] idx_w_i;
  logic       correct_i;
  logic       r_v_i;
  logic [8:0] idx_r_i;
  logic       predict_o;

  int n_cmp  = 0;
  int n_fail = 0;

  bp_fe_gselect dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .w_v_i    (w_v_i),
    .idx_w_i  (idx_w_i),
    .correct_i(correct_i),
    .r_v_i    (r_v_i),
    .idx_r_i  (idx_r_i),
    .predict_o(predict_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change at negedge; one call spans exactly one rising edge.
  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic do_write(input logic [8:0] idx, input logic corr);
    w_v_i = 1'b1; idx_w_i = idx; correct_i = corr; r_v_i = 1'b0;
    step();
    w_v_i = 1'b0;
  endtask

  task automatic do_read(input logic [8:0] idx);
    r_v_i = 1'b1; idx_r_i = idx; w_v_i = 1'b0;
    step();
    r_v_i = 1'b0;
  endtask

  // Six not-taken outcomes on idx 7 entries (counters there only ever decrease) drive GHR to 0.
  task automatic flush_ghr();
    for (int i = 0; i < 6; i++) do_write(9'h007, 1'b1);
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; w_v_i = 1'b0; r_v_i = 1'b0;
    idx_w_i = '0; idx_r_i = '0; correct_i = 1'b0;
    #12;
    n_cmp++;
    if (predict_o !== 1'b0) begin n_fail++; $display("FAIL reset_predict got %0b exp 0", predict_o); end
    step();
    reset_n_i = 1'b1;
    do_read(9'h000);
    n_cmp++;
    if (predict_o !== 1'b0) begin n_fail++; $display("FAIL reset_read0 got %0b exp 0", predict_o); end
    do_read(9'h1FF);
    n_cmp++;
    if (predict_o !== 1'b0) begin n_fail++; $display("FAIL reset_read1ff got %0b exp 0", predict_o); end
    n_cmp++;
    if (dut.ghr_q !== 6'd0) begin n_fail++; $display("FAIL reset_ghr got %0h exp 0", dut.ghr_q); end
    n_cmp++;
    if (dut.cnt_q[9'h140] !== 2'd1) begin n_fail++; $display("FAIL reset_cnt got %0d exp 1", dut.cnt_q[9'h140]); end
  endtask

  task automatic test_mispredict();
    do_write(9'h005, 1'b0);
    n_cmp++;
    if (dut.cnt_q[9'h140] !== 2'd2) begin n_fail++; $display("FAIL mispred_cnt got %0d exp 2", dut.cnt_q[9'h140]); end
    n_cmp++;
    if (dut.ghr_q !== 6'b000001) begin n_fail++; $display("FAIL mispred_ghr got %b exp 000001", dut.ghr_q); end
    do_write(9'h005, 1'b1);
    n_cmp++;
    if (dut.cnt_q[9'h141] !== 2'd0) begin n_fail++; $display("FAIL correct_cnt got %0d exp 0", dut.cnt_q[9'h141]); end
    n_cmp++;
    if (dut.ghr_q !== 6'b000010) begin n_fail++; $display("FAIL correct_ghr got %b exp 000010", dut.ghr_q); end
    flush_ghr();
    n_cmp++;
    if (dut.ghr_q !== 6'd0) begin n_fail++; $display("FAIL flush_ghr got %b exp 0", dut.ghr_q); end
    do_read(9'h005);
    n_cmp++;
    if (predict_o !== 1'b1) begin n_fail++; $display("FAIL mispred_predict got %0b exp 1", predict_o); end
  endtask

  task automatic test_saturation();
    do_write(9'h005, 1'b1);
    flush_ghr();
    do_write(9'h005, 1'b1);
    n_cmp++;
    if (dut.cnt_q[9'h140] !== 2'd3) begin n_fail++; $display("FAIL sat_hi_cnt got %0d exp 3", dut.cnt_q[9'h140]); end
    n_cmp++;
    if (dut.ghr_q !== 6'b000001) begin n_fail++; $display("FAIL sat_hi_ghr got %b exp 000001", dut.ghr_q); end
    do_write(9'h005, 1'b1);
    n_cmp++;
    if (dut.cnt_q[9'h141] !== 2'd0) begin n_fail++; $display("FAIL sat_lo_cnt got %0d exp 0", dut.cnt_q[9'h141]); end
    n_cmp++;
    if (dut.ghr_q !== 6'b000010) begin n_fail++; $display("FAIL sat_lo_ghr got %b exp 000010", dut.ghr_q); end
    flush_ghr();
    do_read(9'h005);
    n_cmp++;
    if (predict_o !== 1'b1) begin n_fail++; $display("FAIL sat_predict got %0b exp 1", predict_o); end
  endtask

  task automatic test_same_cycle();
    r_v_i = 1'b1; idx_r_i = 9'h003;
    w_v_i = 1'b1; idx_w_i = 9'h003; correct_i = 1'b0;
    step();
    w_v_i = 1'b0;
    n_cmp++;
    if (predict_o !== 1'b0) begin n_fail++; $display("FAIL rw_old got %0b exp 0", predict_o); end
    step();
    r_v_i = 1'b0;
    n_cmp++;
    if (predict_o !== 1'b0) begin n_fail++; $display("FAIL rw_newhist got %0b exp 0", predict_o); end
    flush_ghr();
    do_read(9'h003);
    n_cmp++;
    if (predict_o !== 1'b1) begin n_fail++; $display("FAIL rw_written got %0b exp 1", predict_o); end
  endtask

  task automatic test_history();
    do_write(9'h006, 1'b0);
    do_read(9'h006);
    n_cmp++;
    if (predict_o !== 1'b0) begin n_fail++; $display("FAIL hist_ghr1 got %0b exp 0", predict_o); end
    flush_ghr();
    do_read(9'h006);
    n_cmp++;
    if (predict_o !== 1'b1) begin n_fail++; $display("FAIL hist_ghr0 got %0b exp 1", predict_o); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] idxs [4];
    logic       exps [4];
    idxs[0] = 9'h005; exps[0] = 1'b1;
    idxs[1] = 9'h000; exps[1] = 1'b0;
    idxs[2] = 9'h006; exps[2] = 1'b1;
    idxs[3] = 9'h1C5; exps[3] = 1'b1;
    r_v_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idx_r_i = idxs[i];
      step();
      n_cmp++;
      if (predict_o !== exps[i]) begin
        n_fail++; $display("FAIL b2b_%0d got %0b exp %0b", i, predict_o, exps[i]);
      end
    end
    r_v_i = 1'b0;
    step();
    n_cmp++;
    if (predict_o !== 1'b1) begin n_fail++; $display("FAIL b2b_hold got %0b exp 1", predict_o); end
  endtask

  task automatic test_async_reset();
    do_write(9'h005, 1'b1);
    #2 reset_n_i = 1'b0;
    #1;
    n_cmp++;
    if (predict_o !== 1'b0) begin n_fail++; $display("FAIL arst_predict got %0b exp 0", predict_o); end
    n_cmp++;
    if (dut.ghr_q !== 6'd0) begin n_fail++; $display("FAIL arst_ghr got %b exp 0", dut.ghr_q); end
    n_cmp++;
    if (dut.cnt_q[9'h140] !== 2'd1) begin n_fail++; $display("FAIL arst_cnt140 got %0d exp 1", dut.cnt_q[9'h140]); end
    n_cmp++;
    if (dut.cnt_q[9'h180] !== 2'd1) begin n_fail++; $display("FAIL arst_cnt180 got %0d exp 1", dut.cnt_q[9'h180]); end
    step();
    reset_n_i = 1'b1;
    do_read(9'h005);
    n_cmp++;
    if (predict_o !== 1'b0) begin n_fail++; $display("FAIL arst_read got %0b exp 0", predict_o); end
  endtask

  initial begin
    test_reset();
    test_mispredict();
    test_saturation();
    test_same_cycle();
    test_history();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
